axi_wdata_router: RTL

- Next-generation write-data (W) channel router for the AXI node. Buffers routing entries from the AW decoder and forwards W beats to the selected initiator port.
- Each entry carries a one-hot destination, an error flag and the burst length. Error bursts are absorbed internally.
- Adds beat counting, wlast checking or regeneration, and an outstanding-burst count.
- Sits between the AW decoder and the per-port W muxes.

---
 rtl/axi_wdata_router.sv | 134 +++++++++++++
 1 files changed

// File: rtl/axi_wdata_router.sv
// W-channel router: queues AW routing entries and steers W beats to the one-hot destination port.
// Error bursts (flagged or zero destination) are sunk locally; beats are counted against the burst length.
module axi_wdata_router #(
    parameter int N_INIT_PORT = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int LEN_WIDTH   = 8,
    parameter bit ENFORCE_LEN = 1'b0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             route_valid_i,
    output logic                             route_ready_o,
    input  logic [N_INIT_PORT-1:0]           route_dest_i,
    input  logic                             route_err_i,
    input  logic [LEN_WIDTH-1:0]             route_len_i,
    input  logic                             wvalid_i,
    input  logic                             wlast_i,
    output logic                             wready_o,
    output logic [N_INIT_PORT-1:0]           wvalid_o,
    output logic                             wlast_o,
    input  logic [N_INIT_PORT-1:0]           wready_i,
    output logic                             err_burst_done_o,
    output logic                             len_mismatch_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  outstanding_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and ready may depend combinationally on the head entry.

    logic [N_INIT_PORT-1:0] mem_dest [FIFO_DEPTH];
    logic                   mem_err  [FIFO_DEPTH];
    logic [LEN_WIDTH-1:0]   mem_len  [FIFO_DEPTH];

    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [LEN_WIDTH-1:0] cnt;
    logic                 err_done_q;
    logic                 mismatch_q;

    logic                   full;
    logic                   push;
    logic                   pop;
    logic                   head_valid;
    logic [N_INIT_PORT-1:0] head_dest;
    logic                   head_err;
    logic [LEN_WIDTH-1:0]   head_len;
    logic                   calc_last;
    logic                   beat;
    logic                   burst_end;

    assign full          = (count == CNT_FULL);
    assign route_ready_o = ~full;
    assign push          = route_valid_i & ~full;
    assign outstanding_o = count;

    assign head_valid = (count != '0);
    assign head_dest  = mem_dest[rd_ptr];
    assign head_err   = mem_err[rd_ptr];
    assign head_len   = mem_len[rd_ptr];

    always_comb begin
        wvalid_o = '0;
        wready_o = 1'b0;
        if (head_valid) begin
            if (head_err) begin
                wready_o = 1'b1;
            end else begin
                wvalid_o = {N_INIT_PORT{wvalid_i}} & head_dest;
                wready_o = |(wready_i & head_dest);
            end
        end
    end

    assign calc_last = head_valid & (cnt == head_len);
    assign beat      = wvalid_i & wready_o;
    assign burst_end = beat & (ENFORCE_LEN ? calc_last : wlast_i);
    assign pop       = burst_end;
    assign wlast_o   = ENFORCE_LEN ? calc_last : wlast_i;

    // Storage is not reset; the head is only consulted while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_dest[wr_ptr] <= route_dest_i;
            mem_err[wr_ptr]  <= route_err_i | (route_dest_i == '0);
            mem_len[wr_ptr]  <= route_len_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The counter holds at its maximum so an over-long burst cannot alias to a short one.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            err_done_q <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            if (burst_end) begin
                cnt <= '0;
            end else if (beat && (cnt != '1)) begin
                cnt <= cnt + 1'b1;
            end
            err_done_q <= burst_end & head_err;
            mismatch_q <= beat & (wlast_i != calc_last);
        end
    end

    assign err_burst_done_o = err_done_q;
    assign len_mismatch_o   = mismatch_q;

    a_dest_onehot: assert property (@(posedge clk) disable iff (rst)
        (push && !route_err_i) |-> $onehot0(route_dest_i));

endmodule
